axil_up_bridge: RTL and testbench
=================================

# axil_up_bridge

AXI4-Lite slave to UP_WR/UP_RD master bridge. Sits directly upstream of `up_bram` and other UP-bus register/memory blocks: converts processor AXI4-Lite transactions into single-beat UP requests and waits for the UP acknowledge. Write and read paths are independent and may be in flight concurrently.

## Interface
- C_ADDR_WIDTH, 10, UP word-address width.
- C_DATA_WIDTH, 32, data width in bits; only 32 and 64 are legal.
- C_TIMEOUT, 255, cycles to wait for UP ack before an error response, range 1..65535.
- Derived: AW = C_ADDR_WIDTH + log2(C_DATA_WIDTH/8), the AXI byte-address width.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_axi_awaddr  in  AW  write byte address; s_axi_awvalid in 1; s_axi_awready out 1.
- s_axi_wdata  in  C_DATA_WIDTH; s_axi_wstrb in C_DATA_WIDTH/8; s_axi_wvalid in 1; s_axi_wready out 1.
- s_axi_bresp  out  2; s_axi_bvalid out 1; s_axi_bready in 1.
- s_axi_araddr  in  AW; s_axi_arvalid in 1; s_axi_arready out 1.
- s_axi_rdata  out  C_DATA_WIDTH; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1.
- up_wr_addr out C_ADDR_WIDTH; up_wr_be out C_DATA_WIDTH/8; up_wr_req out 1; up_wr_din out C_DATA_WIDTH; up_wr_ack in 1.
- up_rd_addr out C_ADDR_WIDTH; up_rd_req out 1; up_rd_dout in C_DATA_WIDTH; up_rd_ack in 1.
- AWPROT/ARPROT are not ported.

## Operation
- Write FSM: W_IDLE -> W_REQ -> W_WAIT -> W_RESP -> W_IDLE.
  - W_IDLE: awready = wready = awvalid & wvalid & ready_en. Both channels are accepted together in the same cycle, never one alone.
  - On handshake: latch up_wr_addr = awaddr[AW-1:AW-C_ADDR_WIDTH], up_wr_be = wstrb, up_wr_din = wdata; go to W_REQ.
  - W_REQ: up_wr_req = 1 for exactly one cycle; go to W_WAIT.
  - W_WAIT: on up_wr_ack, bresp = 2'b00 and go to W_RESP. On timeout (see Configuration), bresp = 2'b10 (SLVERR) and go to W_RESP.
  - W_RESP: bvalid = 1 until bready; on bvalid & bready go to W_IDLE.
- Read FSM: R_IDLE -> R_REQ -> R_WAIT -> R_RESP -> R_IDLE, mirroring the write FSM.
  - arready = arvalid & ready_en in R_IDLE.
  - On up_rd_ack: rdata = up_rd_dout, rresp = 2'b00. On timeout: rdata = 0, rresp = 2'b10.
- Acks are honoured only in W_WAIT / R_WAIT. An ack in any other state, including a late ack after a timeout, is ignored.
- up_*_addr, up_wr_be and up_wr_din hold their value from the request until the next request.
- ready_en is a flop cleared by reset and set one cycle after rst_n deasserts. All ready outputs are 0 while it is 0.

## Timing
- Reset values: all AXI ready/valid outputs 0, bresp/rresp 2'b00, rdata 0, up_wr_req/up_rd_req 0, up_* addr/be/din 0, FSMs in IDLE, timeout counters 0.
- Reset asserted mid-transaction: FSMs abort to IDLE immediately. No response is issued for the aborted transaction, and a pending ack after reset is ignored.
- Write latency: AW/W handshake at cycle N -> up_wr_req in N+1. Ack at cycle N+1+k (k ≥ 1) -> bvalid at N+2+k. For `up_bram` (k=1), bvalid is at N+3.
- Read latency: identical, with rdata valid together with rvalid.
- An ack in the same cycle as req (k=0) is not sampled. UP targets must ack no earlier than one cycle after req.
- Each path has one outstanding transaction. No new AW/W/AR is accepted until the corresponding B/R handshake completes.
- bvalid/rvalid stay stable, with stable bresp/rresp/rdata, under backpressure.

## Configuration
- Macro `AXIL_UP_BRIDGE_TIMEOUT_EN`.
- Defined: one 16-bit counter per path, cleared on entry to WAIT and incremented each cycle in WAIT. When the count equals C_TIMEOUT with no ack, the transaction completes with SLVERR (rdata = 0 for reads).
- Undefined: no counters. WAIT holds indefinitely until ack, resp is always OKAY, and C_TIMEOUT is unused.

## Test plan
- Write to `up_bram`: awaddr 0x010, wdata 0xDEADBEEF, wstrb 0xF -> up_wr_req at N+1 with up_wr_addr 4, up_wr_be 0xF; bvalid at N+3 with bresp 00.
- Read back: araddr 0x010 -> up_rd_addr 4; rvalid with rdata 0xDEADBEEF, rresp 00. A partial write with wstrb 0x3 and wdata 0x0000AAAA, followed by a read, returns 0xDEADAAAA.
- AW valid held 5 cycles before W valid -> awready/wready stay 0 until both are valid, then assert together for one cycle; exactly one up_wr_req.
- Backpressure: bready held low 10 cycles -> bvalid and bresp stable; no new awready during that time. The same check applies to rready/rvalid.
- Timeout (macro defined, C_TIMEOUT=8): target never acks -> rvalid exactly 8 cycles after entering R_WAIT, with rresp 10 and rdata 0. An ack injected 3 cycles later is ignored and the next read completes normally.
- Concurrency and reset: issue a write and a read in the same cycle -> both up_*_req fire in the same cycle and both complete. Pull rst_n low while in W_WAIT -> all outputs go to reset values asynchronously and no bvalid is seen after release.

Source files
------------

// File: rtl/axil_up_bridge.sv
// ---------------------------------------------------------------------------
// axil_up_bridge
//   AXI4-Lite slave to UP_WR / UP_RD master bridge. Each AXI transaction is
//   turned into a single one-cycle UP request, and the bridge then waits for
//   the UP acknowledge. The write and read paths are independent and may be
//   in flight at the same time. Each path has at most one transaction
//   outstanding.
//
//   Optional feature macro: AXIL_UP_BRIDGE_TIMEOUT_EN
//     defined   : each path has a 16-bit wait counter. After C_TIMEOUT cycles
//                 in WAIT with no ack, the transaction ends with SLVERR
//                 (rdata = 0 for reads).
//     undefined : WAIT holds until ack, the response is always OKAY and
//                 C_TIMEOUT is unused.
//
// Parameters
//   C_ADDR_WIDTH   UP word-address width
//   C_DATA_WIDTH   data width, 32 or 64
//   C_TIMEOUT      ack wait budget in cycles, 1..65535
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   s_axi_aw*/w*/b*            AXI4-Lite write address/data/response
//   s_axi_ar*/r*               AXI4-Lite read address/data
//   up_wr_addr/be/req/din/ack  UP write request and acknowledge
//   up_rd_addr/req/dout/ack    UP read request, data and acknowledge
// ---------------------------------------------------------------------------
module axil_up_bridge #(
    parameter int unsigned C_ADDR_WIDTH = 10,
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned C_TIMEOUT    = 255
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [C_ADDR_WIDTH+$clog2(C_DATA_WIDTH/8)-1:0]    s_axi_awaddr,
    input  logic                                              s_axi_awvalid,
    output logic                                              s_axi_awready,
    input  logic [C_DATA_WIDTH-1:0]                           s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0]                         s_axi_wstrb,
    input  logic                                              s_axi_wvalid,
    output logic                                              s_axi_wready,
    output logic [1:0]                                        s_axi_bresp,
    output logic                                              s_axi_bvalid,
    input  logic                                              s_axi_bready,
    input  logic [C_ADDR_WIDTH+$clog2(C_DATA_WIDTH/8)-1:0]    s_axi_araddr,
    input  logic                                              s_axi_arvalid,
    output logic                                              s_axi_arready,
    output logic [C_DATA_WIDTH-1:0]                           s_axi_rdata,
    output logic [1:0]                                        s_axi_rresp,
    output logic                                              s_axi_rvalid,
    input  logic                                              s_axi_rready,
    output logic [C_ADDR_WIDTH-1:0]                           up_wr_addr,
    output logic [C_DATA_WIDTH/8-1:0]                         up_wr_be,
    output logic                                              up_wr_req,
    output logic [C_DATA_WIDTH-1:0]                           up_wr_din,
    input  logic                                              up_wr_ack,
    output logic [C_ADDR_WIDTH-1:0]                           up_rd_addr,
    output logic                                              up_rd_req,
    input  logic [C_DATA_WIDTH-1:0]                           up_rd_dout,
    input  logic                                              up_rd_ack
);

    localparam int unsigned SW = C_DATA_WIDTH / 8;
    localparam int unsigned AW = C_ADDR_WIDTH + $clog2(SW);
    localparam int unsigned LW = AW - C_ADDR_WIDTH;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic ready_en;
    logic w_timeout;
    logic r_timeout;

    // The byte-lane bits of the AXI address carry no information on the UP side
    logic unused_addr;
    assign unused_addr = ^{s_axi_awaddr[LW-1:0], s_axi_araddr[LW-1:0]};

    // Holds the ready outputs low for the first cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // ------------------------------------------------------------ write FSM
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // Next state; an ack takes priority over a coinciding timeout
    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (s_axi_awready)            w_next = W_REQ;
            W_REQ:                                 w_next = W_WAIT;
            W_WAIT:  if (up_wr_ack || w_timeout)   w_next = W_RESP;
            W_RESP:  if (s_axi_bready)             w_next = W_IDLE;
            default:                               w_next = W_IDLE;
        endcase
    end

    // Outputs; AW and W are only ever accepted together
    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        up_wr_req     = 1'b0;
        s_axi_bvalid  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                s_axi_awready = s_axi_awvalid & s_axi_wvalid & ready_en;
                s_axi_wready  = s_axi_awvalid & s_axi_wvalid & ready_en;
            end
            W_REQ:   up_wr_req    = 1'b1;
            W_WAIT:  ;
            W_RESP:  s_axi_bvalid = 1'b1;
            default: ;
        endcase
    end

    // Write request payload and response code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_wr_addr  <= '0;
            up_wr_be    <= '0;
            up_wr_din   <= '0;
            s_axi_bresp <= RESP_OKAY;
        end else begin
            if (s_axi_awready) begin
                up_wr_addr <= s_axi_awaddr[AW-1 -: C_ADDR_WIDTH];
                up_wr_be   <= s_axi_wstrb;
                up_wr_din  <= s_axi_wdata;
            end
            if (w_state == W_WAIT) begin
                if (up_wr_ack) begin
                    s_axi_bresp <= RESP_OKAY;
                end else if (w_timeout) begin
                    s_axi_bresp <= RESP_SLVERR;
                end
            end
        end
    end

    // ------------------------------------------------------------- read FSM
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    // Next state; an ack takes priority over a coinciding timeout
    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (s_axi_arready)            r_next = R_REQ;
            R_REQ:                                 r_next = R_WAIT;
            R_WAIT:  if (up_rd_ack || r_timeout)   r_next = R_RESP;
            R_RESP:  if (s_axi_rready)             r_next = R_IDLE;
            default:                               r_next = R_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        s_axi_arready = 1'b0;
        up_rd_req     = 1'b0;
        s_axi_rvalid  = 1'b0;
        unique case (r_state)
            R_IDLE:  s_axi_arready = s_axi_arvalid & ready_en;
            R_REQ:   up_rd_req     = 1'b1;
            R_WAIT:  ;
            R_RESP:  s_axi_rvalid  = 1'b1;
            default: ;
        endcase
    end

    // Read request address, captured data and response code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_rd_addr  <= '0;
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else begin
            if (s_axi_arready) begin
                up_rd_addr <= s_axi_araddr[AW-1 -: C_ADDR_WIDTH];
            end
            if (r_state == R_WAIT) begin
                if (up_rd_ack) begin
                    s_axi_rdata <= up_rd_dout;
                    s_axi_rresp <= RESP_OKAY;
                end else if (r_timeout) begin
                    s_axi_rdata <= '0;
                    s_axi_rresp <= RESP_SLVERR;
                end
            end
        end
    end

    // ---------------------------------------------------------- ack timeout
`ifdef AXIL_UP_BRIDGE_TIMEOUT_EN
    // Counters read 0 in the first WAIT cycle, so firing on C_TIMEOUT-1
    // keeps each path in WAIT for exactly C_TIMEOUT cycles.
    localparam logic [15:0] TO_LAST = 16'(C_TIMEOUT - 1);

    logic [15:0] w_cnt;
    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_cnt <= 16'd0;
        end else if (w_state == W_REQ) begin
            w_cnt <= 16'd0;
        end else if (w_state == W_WAIT) begin
            w_cnt <= w_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (r_state == R_REQ) begin
            r_cnt <= 16'd0;
        end else if (r_state == R_WAIT) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign w_timeout = (w_state == W_WAIT) && (w_cnt == TO_LAST);
    assign r_timeout = (r_state == R_WAIT) && (r_cnt == TO_LAST);
`else
    logic unused_cfg;
    assign unused_cfg = ^(16'(C_TIMEOUT));
    assign w_timeout  = 1'b0;
    assign r_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_axil_up_bridge.sv
// ---------------------------------------------------------------------------
// tb_axil_up_bridge
//   Randomised and directed stimulus with a transaction-level reference
//   memory. Expected UP requests and AXI responses are queued at issue time
//   and popped by independent monitors when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_axil_up_bridge;

    localparam int unsigned AWD = 10;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 4;
    localparam int unsigned AW  = 12;
    localparam int unsigned TO  = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   s_axi_awaddr = '0;
    logic            s_axi_awvalid = 1'b0;
    logic            s_axi_awready;
    logic [DW-1:0]   s_axi_wdata = '0;
    logic [SW-1:0]   s_axi_wstrb = '0;
    logic            s_axi_wvalid = 1'b0;
    logic            s_axi_wready;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic            s_axi_bready = 1'b1;
    logic [AW-1:0]   s_axi_araddr = '0;
    logic            s_axi_arvalid = 1'b0;
    logic            s_axi_arready;
    logic [DW-1:0]   s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rvalid;
    logic            s_axi_rready = 1'b1;
    logic [AWD-1:0]  up_wr_addr;
    logic [SW-1:0]   up_wr_be;
    logic            up_wr_req;
    logic [DW-1:0]   up_wr_din;
    logic            up_wr_ack = 1'b0;
    logic [AWD-1:0]  up_rd_addr;
    logic            up_rd_req;
    logic [DW-1:0]   up_rd_dout = '0;
    logic            up_rd_ack = 1'b0;

    axil_up_bridge #(
        .C_ADDR_WIDTH (AWD),
        .C_DATA_WIDTH (DW),
        .C_TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .up_wr_addr    (up_wr_addr),
        .up_wr_be      (up_wr_be),
        .up_wr_req     (up_wr_req),
        .up_wr_din     (up_wr_din),
        .up_wr_ack     (up_wr_ack),
        .up_rd_addr    (up_rd_addr),
        .up_rd_req     (up_rd_req),
        .up_rd_dout    (up_rd_dout),
        .up_rd_ack     (up_rd_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] din;
        int          cyc;
    } upr_t;

    rsp_t exp_b[$];
    rsp_t exp_r[$];
    upr_t exp_upw[$];
    upr_t exp_upr[$];

    logic [31:0] ref_mem [1024];
    logic [31:0] tgt_mem [1024];

    int wr_k = 1;
    int rd_k = 1;
    bit rd_noack = 1'b0;
    int last_w_hs = 0;
    int last_r_hs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // UP write target: applies byte enables, acks wr_k cycles after the request
    initial begin
        forever begin
            @(negedge clk);
            if (up_wr_req) begin
                int k;
                k = wr_k;
                for (int b = 0; b < 4; b++)
                    if (up_wr_be[b]) tgt_mem[up_wr_addr][8*b +: 8] = up_wr_din[8*b +: 8];
                repeat (k) @(posedge clk);
                #1 up_wr_ack = 1'b1;
                @(posedge clk);
                #1 up_wr_ack = 1'b0;
            end
        end
    end

    // UP read target: returns memory data, or stays silent and acks far too late
    initial begin
        forever begin
            @(negedge clk);
            if (up_rd_req) begin
                logic [31:0] d;
                int k;
                d = tgt_mem[up_rd_addr];
                k = rd_k;
                if (rd_noack) begin
                    repeat (TO + 3) @(posedge clk);
                    #1 up_rd_dout = $urandom;
                    up_rd_ack = 1'b1;
                end else begin
                    repeat (k) @(posedge clk);
                    #1 up_rd_dout = d;
                    up_rd_ack = 1'b1;
                end
                @(posedge clk);
                #1 up_rd_ack = 1'b0;
                up_rd_dout = $urandom;
            end
        end
    end

    // UP request monitors
    always @(negedge clk) begin : mon_upw
        upr_t e;
        if (up_wr_req) begin
            if (exp_upw.size() == 0) fail("unexpected_up_wr_req");
            else begin
                e = exp_upw.pop_front();
                chk("up_wr_addr", up_wr_addr, e.addr);
                chk("up_wr_be", up_wr_be, e.be);
                chk("up_wr_din", up_wr_din, e.din);
                chk("up_wr_req_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon_upr
        upr_t e;
        if (up_rd_req) begin
            if (exp_upr.size() == 0) fail("unexpected_up_rd_req");
            else begin
                e = exp_upr.pop_front();
                chk("up_rd_addr", up_rd_addr, e.addr);
                chk("up_rd_req_cycle", cyc, e.cyc);
            end
        end
    end

    // B channel monitor: first-valid cycle, response, stability, AW blocking
    logic       b_held = 1'b0;
    logic [1:0] b_hold;
    always @(negedge clk) begin : mon_b
        rsp_t e;
        if (s_axi_bvalid) begin
            if (!b_held) begin
                if (exp_b.size() == 0) fail("unexpected_bvalid");
                else begin
                    e = exp_b[0];
                    chk("bresp", s_axi_bresp, e.resp);
                    chk("bvalid_cycle", cyc, e.cyc);
                end
            end else begin
                chk("bresp_stable", s_axi_bresp, b_hold);
            end
            chk("awready_while_bvalid", {s_axi_awready, s_axi_wready}, 2'b00);
            b_hold = s_axi_bresp;
            if (s_axi_bready && exp_b.size() > 0) void'(exp_b.pop_front());
        end
        b_held = s_axi_bvalid && !s_axi_bready;
    end

    // R channel monitor
    logic        r_held = 1'b0;
    logic [33:0] r_hold;
    always @(negedge clk) begin : mon_r
        rsp_t e;
        if (s_axi_rvalid) begin
            if (!r_held) begin
                if (exp_r.size() == 0) fail("unexpected_rvalid");
                else begin
                    e = exp_r[0];
                    chk("rresp", s_axi_rresp, e.resp);
                    chk("rdata", s_axi_rdata, e.data);
                    chk("rvalid_cycle", cyc, e.cyc);
                end
            end else begin
                chk("r_stable", {s_axi_rresp, s_axi_rdata}, r_hold);
            end
            chk("arready_while_rvalid", s_axi_arready, 1'b0);
            r_hold = {s_axi_rresp, s_axi_rdata};
            if (s_axi_rready && exp_r.size() > 0) void'(exp_r.pop_front());
        end
        r_held = s_axi_rvalid && !s_axi_rready;
    end

    // Issue one write; aw_lead cycles of AW alone precede W
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int k, input int aw_lead);
        bit done;
        int n;
        done = 1'b0;
        wr_k = k;
        s_axi_awaddr  = a;
        s_axi_wdata   = d;
        s_axi_wstrb   = s;
        s_axi_awvalid = 1'b1;
        repeat (aw_lead) begin
            @(negedge clk);
            chk("aw_alone_ready", {s_axi_awready, s_axi_wready}, 2'b00);
            @(posedge clk);
            #1;
        end
        s_axi_wvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            chk("awready_eq_wready", s_axi_awready, s_axi_wready);
            if (s_axi_awready && s_axi_wready) begin
                done = 1'b1;
                n = cyc;
                last_w_hs = n;
                exp_upw.push_back('{a[11:2], s, d, n + 1});
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
                exp_b.push_back('{2'b00, 32'h0, n + 2 + k});
            end
            @(posedge clk);
            #1;
        end
        if (!done) fail("aw_w_handshake_timeout");
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
    endtask

    // Issue one read; the expected data comes from the reference memory
    task automatic axi_read(input logic [11:0] a, input int k);
        bit done;
        int n;
        done = 1'b0;
        rd_k = k;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (s_axi_arready) begin
                done = 1'b1;
                n = cyc;
                last_r_hs = n;
                exp_upr.push_back('{a[11:2], 4'h0, 32'h0, n + 1});
                if (rd_noack) exp_r.push_back('{2'b10, 32'h0, n + 2 + int'(TO)});
                else          exp_r.push_back('{2'b00, ref_mem[a[11:2]], n + 2 + k});
            end
            @(posedge clk);
            #1;
        end
        if (!done) fail("ar_handshake_timeout");
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = (exp_b.size() == 0) && (exp_r.size() == 0) &&
                 (exp_upw.size() == 0) && (exp_upr.size() == 0);
        end
        if (!ok) fail("response_wait_timeout");
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        chk("rst_valid", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
        chk("rst_resp", {s_axi_bresp, s_axi_rresp}, 4'h0);
        chk("rst_rdata", s_axi_rdata, 32'h0);
        chk("rst_req", {up_wr_req, up_rd_req}, 2'b00);
        chk("rst_up_addr", {up_wr_addr, up_rd_addr}, 20'h0);
        chk("rst_up_be_din", {up_wr_be, up_wr_din}, 36'h0);
    endtask

    // Release reset and confirm ready stays low for the first cycle
    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        chk("ready_en_first_cycle", s_axi_arready, 1'b0);
        @(posedge clk);
        #1 s_axi_arvalid = 1'b0;
    endtask

    initial begin
        #1ms;
        fail("watchdog");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [11:0] a;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = 32'h0;
            tgt_mem[i] = 32'h0;
        end

        repeat (3) @(posedge clk);
        #1 chk_reset_vals();
        release_reset();
        repeat (2) @(posedge clk);
        #1;

        // Full write, read back, partial write, read back
        axi_write(12'h010, 32'hDEADBEEF, 4'hF, 1, 0);
        wait_idle(50);
        axi_read(12'h010, 1);
        wait_idle(50);
        axi_write(12'h010, 32'h0000AAAA, 4'h3, 1, 0);
        wait_idle(50);
        axi_read(12'h010, 1);
        wait_idle(50);

        // AW presented 5 cycles before W, slower target
        axi_write(12'h024, 32'h12345678, 4'hC, 3, 5);
        wait_idle(50);

        // Write response backpressure with a competing AW/W held
        s_axi_bready = 1'b0;
        axi_write(12'h030, 32'hCAFEF00D, 4'hF, 1, 0);
        s_axi_awaddr  = 12'h040;
        s_axi_wdata   = 32'h55555555;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        repeat (12) @(posedge clk);
        #1 s_axi_bready = 1'b1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        wait_idle(50);

        // Read response backpressure with a competing AR held
        s_axi_rready = 1'b0;
        axi_read(12'h030, 2);
        s_axi_araddr  = 12'h044;
        s_axi_arvalid = 1'b1;
        repeat (12) @(posedge clk);
        #1 s_axi_rready = 1'b1;
        s_axi_arvalid = 1'b0;
        wait_idle(50);

`ifdef AXIL_UP_BRIDGE_TIMEOUT_EN
        // Silent target, then a late ack that must be ignored
        rd_noack = 1'b1;
        axi_read(12'h050, 1);
        wait_idle(50);
        rd_noack = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        axi_read(12'h010, 1);
        wait_idle(50);
`endif

        // Concurrent write and read to different words
        fork
            axi_write(12'h060, 32'hA5A5A5A5, 4'hF, 2, 0);
            axi_read(12'h024, 1);
        join
        chk("concurrent_hs_cycle", last_w_hs, last_r_hs);
        wait_idle(50);

        // Reset while waiting for a write ack; the late ack must be ignored
        axi_write(12'h070, 32'h0BADF00D, 4'hF, 8, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        exp_b.delete();
        repeat (3) @(posedge clk);
        release_reset();
        repeat (15) @(posedge clk);
        #1;

        // Randomised traffic over a small window so reads hit written data
        for (int it = 0; it < 60; it++) begin
            a = {6'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom), $urandom_range(1, 4), $urandom_range(0, 2));
            else
                axi_read(a, $urandom_range(1, 4));
            wait_idle(100);
        end

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
